eth_pcs_block_sync: RTL and testbench
=====================================

// Module: eth_pcs_block_sync
// PURPOSE
// Receive-side block-lock controller for the 10GBASE-R PCS (IEEE 802.3 Cl.49 lock FSM).
// - Sits between the RX gearbox and the 66/64 decoder.
// - Inspects every sync header presented with the gearbox header strobe and drives the gearbox slip request.
// - Declares block lock; the decoder output is trusted only while o_block_lock=1.
// - Keeps a saturating count of invalid headers for status.
// PARAMETERS
// SH_CNT_MAX    64  headers per test window; consecutive valid headers needed for lock
// SH_INVLD_MAX  16  invalid headers within one window that drop lock
// SLIP_WAIT     32  headers ignored after a slip while the gearbox realigns
// W_ERR_CNT     16  width of invalid-header status counter
// PORTS
// i_clk            in   1       PCS RX clock (single clock domain)
// i_reset          in   1       asynchronous, active-high reset
// i_clk_en         in   1       gearbox clock enable; all state updates are qualified by it
// i_grbx_hdr_valid in   1       i_grbx_hdr carries a new block's sync header this cycle
// i_grbx_hdr       in   W_SYNC  sync header (SYNC_DATA / SYNC_CTRL valid, others invalid)
// i_err_cnt_clr    in   1       synchronous clear of o_sh_err_cnt
// o_grbx_slip      out  1       request gearbox to shift block boundary by one bit
// o_block_lock     out  1       block lock achieved
// o_sh_err_cnt     out  W_ERR_CNT saturating count of invalid headers
// BEHAVIOUR
// - Header event (hev) = i_clk_en & i_grbx_hdr_valid; no state changes on other cycles (except slip clear, err clear).
// - sh_ok = (i_grbx_hdr==SYNC_DATA)|(i_grbx_hdr==SYNC_CTRL).
// - Counters: sh_cnt $clog2(SH_CNT_MAX+1) b, invld_cnt $clog2(SH_INVLD_MAX+1) b, wait_cnt $clog2(SLIP_WAIT+1) b.
// - Reset (async): state=UNLOCKED, all counters 0, o_block_lock=0, o_grbx_slip=0, o_sh_err_cnt=0.
//   - Reset mid-operation (incl. SLIP_WAIT) aborts immediately to these values.
// - UNLOCKED, on hev:
//   - sh_ok: sh_cnt++. On reaching SH_CNT_MAX: o_block_lock<=1, counters<=0, ->LOCKED.
//   - !sh_ok: ->SLIP.
// - LOCKED, on hev:
//   - sh_cnt++; invld_cnt++ if !sh_ok.
//   - invld_cnt reaching SH_INVLD_MAX: o_block_lock<=0, ->SLIP. Takes priority over window end on the same header.
//   - Else sh_cnt reaching SH_CNT_MAX: both counters<=0, stay LOCKED.
// - SLIP (entered from either state):
//   - Registered o_grbx_slip=1 from the cycle after the causing header.
//   - Held until a cycle with i_clk_en=1 has sampled it; cleared at the end of that cycle (exactly one gearbox-enabled cycle).
//   - Counters<=0; ->SLIP_WAIT on the same edge that clears slip.
// - SLIP_WAIT:
//   - Headers ignored (no error counting); wait_cnt++ per hev.
//   - At SLIP_WAIT: wait_cnt<=0, ->UNLOCKED.
// - Latency: o_block_lock changes one i_clk after the deciding header cycle.
// - o_sh_err_cnt increments on every !sh_ok hev in UNLOCKED/LOCKED; saturates at all-ones.
//   - i_err_cnt_clr has priority: counter<=0 and a simultaneous error is dropped.
// - o_block_lock only rises from UNLOCKED after SH_CNT_MAX consecutive valid headers.
// TESTING
// - 64 valid headers from reset -> o_block_lock=1 the cycle after header 64; o_grbx_slip never asserted.
// - Invalid header #10 while unlocked -> one slip (high exactly one clk_en cycle).
//   - Next 32 headers ignored (incl. invalid); 64 valid after that -> lock.
// - Locked, 15 invalid in a 64-header window -> lock held, counters reset.
//   - 16th invalid within a window -> lock=0 next cycle, slip issued.
// - hdr_valid=1 with clk_en=0 (invalid header) -> no state, counter or output change.
//   - Slip pending across a clk_en=0 gap stays high until the next clk_en=1 cycle.
// - Force o_sh_err_cnt to 16'hFFFF via invalid headers -> holds 16'hFFFF.
//   - Clear coincident with an invalid header -> 0.
// - Assert i_reset during SLIP_WAIT -> lock=0, slip=0, err cnt=0 immediately.
//   - 64 valid headers after release -> lock.

Source files
------------

// File: rtl/eth_pcs_block_sync.sv
// 10GBASE-R receive block-lock controller: qualifies 66b sync headers from the
// RX gearbox, requests bit slips while hunting, and reports block lock.
module eth_pcs_block_sync #(
  parameter int unsigned SH_CNT_MAX   = 64,
  parameter int unsigned SH_INVLD_MAX = 16,
  parameter int unsigned SLIP_WAIT    = 32,
  parameter int unsigned W_ERR_CNT    = 16,
  parameter int unsigned W_SYNC       = 2,
  parameter logic [W_SYNC-1:0] SYNC_DATA = W_SYNC'(2'b01),
  parameter logic [W_SYNC-1:0] SYNC_CTRL = W_SYNC'(2'b10)
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_clk_en,
  input  logic                 i_grbx_hdr_valid,
  input  logic [W_SYNC-1:0]    i_grbx_hdr,
  input  logic                 i_err_cnt_clr,
  output logic                 o_grbx_slip,
  output logic                 o_block_lock,
  output logic [W_ERR_CNT-1:0] o_sh_err_cnt
);

  localparam int unsigned SH_W   = $clog2(SH_CNT_MAX + 1);
  localparam int unsigned INV_W  = $clog2(SH_INVLD_MAX + 1);
  localparam int unsigned WAIT_W = $clog2(SLIP_WAIT + 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED,
    ST_LOCKED,
    ST_SLIP,
    ST_SLIP_WAIT
  } state_t;

  state_t              state;
  logic [SH_W-1:0]     sh_cnt;
  logic [INV_W-1:0]    invld_cnt;
  logic [WAIT_W-1:0]   wait_cnt;

  logic                hev;
  logic                sh_ok;
  logic [SH_W-1:0]     sh_cnt_inc;
  logic [INV_W-1:0]    invld_cnt_inc;
  logic [WAIT_W-1:0]   wait_cnt_inc;
  logic                sh_done;
  logic                invld_done;
  logic                wait_done;
  logic                err_event;

  assign hev           = i_clk_en & i_grbx_hdr_valid;
  assign sh_ok         = (i_grbx_hdr == SYNC_DATA) | (i_grbx_hdr == SYNC_CTRL);
  assign sh_cnt_inc    = sh_cnt + SH_W'(1);
  assign invld_cnt_inc = invld_cnt + INV_W'(~sh_ok);
  assign wait_cnt_inc  = wait_cnt + WAIT_W'(1);
  assign sh_done       = (sh_cnt_inc == SH_W'(SH_CNT_MAX));
  assign invld_done    = (invld_cnt_inc == INV_W'(SH_INVLD_MAX));
  assign wait_done     = (wait_cnt_inc == WAIT_W'(SLIP_WAIT));
  assign err_event     = hev & ~sh_ok & ((state == ST_UNLOCKED) | (state == ST_LOCKED));

  // Lock FSM with its window counters and registered slip/lock outputs
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_UNLOCKED;
      sh_cnt       <= '0;
      invld_cnt    <= '0;
      wait_cnt     <= '0;
      o_block_lock <= 1'b0;
      o_grbx_slip  <= 1'b0;
    end else begin
      case (state)
        ST_UNLOCKED: begin
          if (hev) begin
            if (sh_ok) begin
              if (sh_done) begin
                o_block_lock <= 1'b1;
                sh_cnt       <= '0;
                invld_cnt    <= '0;
                state        <= ST_LOCKED;
              end else begin
                sh_cnt <= sh_cnt_inc;
              end
            end else begin
              sh_cnt      <= '0;
              invld_cnt   <= '0;
              o_grbx_slip <= 1'b1;
              state       <= ST_SLIP;
            end
          end
        end
        ST_LOCKED: begin
          // Too many bad headers wins over a window closing on the same header
          if (hev) begin
            if (invld_done) begin
              o_block_lock <= 1'b0;
              o_grbx_slip  <= 1'b1;
              sh_cnt       <= '0;
              invld_cnt    <= '0;
              state        <= ST_SLIP;
            end else if (sh_done) begin
              sh_cnt    <= '0;
              invld_cnt <= '0;
            end else begin
              sh_cnt    <= sh_cnt_inc;
              invld_cnt <= invld_cnt_inc;
            end
          end
        end
        ST_SLIP: begin
          // Slip must be seen by exactly one gearbox-enabled cycle
          if (i_clk_en) begin
            o_grbx_slip <= 1'b0;
            sh_cnt      <= '0;
            invld_cnt   <= '0;
            wait_cnt    <= '0;
            state       <= ST_SLIP_WAIT;
          end
        end
        ST_SLIP_WAIT: begin
          if (hev) begin
            if (wait_done) begin
              wait_cnt <= '0;
              state    <= ST_UNLOCKED;
            end else begin
              wait_cnt <= wait_cnt_inc;
            end
          end
        end
        default: begin
          state <= ST_UNLOCKED;
        end
      endcase
    end
  end

  // Saturating invalid-header status counter; clear beats a coincident error
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_sh_err_cnt <= '0;
    end else if (i_err_cnt_clr) begin
      o_sh_err_cnt <= '0;
    end else if (err_event && (o_sh_err_cnt != {W_ERR_CNT{1'b1}})) begin
      o_sh_err_cnt <= o_sh_err_cnt + W_ERR_CNT'(1);
    end
  end

endmodule

// File: tb/tb_eth_pcs_block_sync.sv
// Directed bench for eth_pcs_block_sync: a behavioural lock model feeds a
// per-cycle scoreboard, plus directed checks at the interesting points.
module tb_eth_pcs_block_sync;

  localparam int unsigned SH_CNT_MAX   = 64;
  localparam int unsigned SH_INVLD_MAX = 16;
  localparam int unsigned SLIP_WAIT    = 32;
  localparam int unsigned W_ERR        = 8;
  localparam int unsigned ERR_MAX      = (1 << W_ERR) - 1;
  localparam logic [1:0]  HD  = 2'b01;
  localparam logic [1:0]  HC  = 2'b10;
  localparam logic [1:0]  HB0 = 2'b00;
  localparam logic [1:0]  HB1 = 2'b11;

  logic             i_clk;
  logic             i_reset;
  logic             i_clk_en;
  logic             i_grbx_hdr_valid;
  logic [1:0]       i_grbx_hdr;
  logic             i_err_cnt_clr;
  logic             o_grbx_slip;
  logic             o_block_lock;
  logic [W_ERR-1:0] o_sh_err_cnt;

  typedef struct packed {
    logic             lock;
    logic             slip;
    logic [W_ERR-1:0] err;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   slip_en_cycles = 0;
  logic slip_seen = 1'b0;

  // Behavioural model state: 0 unlocked, 1 locked, 2 slip, 3 slip wait
  int   m_state, m_run, m_win, m_bad, m_wait, m_err;
  logic m_lock, m_slip;

  eth_pcs_block_sync #(
    .SH_CNT_MAX  (SH_CNT_MAX),
    .SH_INVLD_MAX(SH_INVLD_MAX),
    .SLIP_WAIT   (SLIP_WAIT),
    .W_ERR_CNT   (W_ERR)
  ) dut (
    .i_clk           (i_clk),
    .i_reset         (i_reset),
    .i_clk_en        (i_clk_en),
    .i_grbx_hdr_valid(i_grbx_hdr_valid),
    .i_grbx_hdr      (i_grbx_hdr),
    .i_err_cnt_clr   (i_err_cnt_clr),
    .o_grbx_slip     (o_grbx_slip),
    .o_block_lock    (o_block_lock),
    .o_sh_err_cnt    (o_sh_err_cnt)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_run = 0; m_win = 0; m_bad = 0; m_wait = 0; m_err = 0;
    m_lock = 1'b0; m_slip = 1'b0;
  endtask

  task automatic model_step(input logic en, input logic valid, input logic [1:0] hdr,
                            input logic clr);
    bit hev, ok;
    hev = en && valid;
    ok  = (hdr == HD) || (hdr == HC);
    if (clr) m_err = 0;
    else if (hev && !ok && m_state <= 1 && m_err < int'(ERR_MAX)) m_err++;
    case (m_state)
      0: if (hev) begin
        if (ok) begin
          m_run++;
          if (m_run == int'(SH_CNT_MAX)) begin
            m_lock = 1'b1; m_run = 0; m_win = 0; m_bad = 0; m_state = 1;
          end
        end else begin
          m_run = 0; m_slip = 1'b1; m_state = 2;
        end
      end
      1: if (hev) begin
        m_win++;
        if (!ok) m_bad++;
        if (m_bad == int'(SH_INVLD_MAX)) begin
          m_lock = 1'b0; m_slip = 1'b1; m_win = 0; m_bad = 0; m_state = 2;
        end else if (m_win == int'(SH_CNT_MAX)) begin
          m_win = 0; m_bad = 0;
        end
      end
      2: if (en) begin
        m_slip = 1'b0; m_wait = 0; m_state = 3;
      end
      default: if (hev) begin
        m_wait++;
        if (m_wait == int'(SLIP_WAIT)) begin
          m_wait = 0; m_run = 0; m_state = 0;
        end
      end
    endcase
  endtask

  // Drive one cycle, queue the model's expectation, compare after the edge
  task automatic step(input logic en, input logic valid, input logic [1:0] hdr,
                      input logic clr);
    exp_t e;
    i_clk_en = en; i_grbx_hdr_valid = valid; i_grbx_hdr = hdr; i_err_cnt_clr = clr;
    model_step(en, valid, hdr, clr);
    e.lock = m_lock; e.slip = m_slip; e.err = W_ERR'(m_err);
    sb_q.push_back(e);
    if (o_grbx_slip && en) slip_en_cycles++;
    @(posedge i_clk);
    #1;
    e = sb_q.pop_front();
    if (o_grbx_slip) slip_seen = 1'b1;
    check("sb_lock", 32'(o_block_lock), 32'(e.lock));
    check("sb_slip", 32'(o_grbx_slip), 32'(e.slip));
    check("sb_err", 32'(o_sh_err_cnt), 32'(e.err));
  endtask

  task automatic valid_hdrs(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, (i % 2 == 0) ? HD : HC, 1'b0);
  endtask

  task automatic ign_hdrs(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, (i % 3 == 0) ? HB0 : HD, 1'b0);
  endtask

  task automatic window(input int nbad);
    for (int i = 0; i < int'(SH_CNT_MAX); i++) step(1'b1, 1'b1, (i < nbad) ? HB1 : HD, 1'b0);
  endtask

  // Asynchronous reset pulse in the middle of a clock phase
  task automatic do_reset();
    i_clk_en = 1'b0; i_grbx_hdr_valid = 1'b0; i_err_cnt_clr = 1'b0;
    #2 i_reset = 1'b1;
    #1;
    check("rst_lock", 32'(o_block_lock), 32'd0);
    check("rst_slip", 32'(o_grbx_slip), 32'd0);
    check("rst_err", 32'(o_sh_err_cnt), 32'd0);
    model_reset();
    sb_q.delete();
    #2 i_reset = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_reset = 1'b1; i_clk_en = 1'b0; i_grbx_hdr_valid = 1'b0;
    i_grbx_hdr = HD; i_err_cnt_clr = 1'b0;
    model_reset();
    repeat (2) @(posedge i_clk);
    #1;
    check("init_lock", 32'(o_block_lock), 32'd0);
    check("init_slip", 32'(o_grbx_slip), 32'd0);
    check("init_err", 32'(o_sh_err_cnt), 32'd0);
    i_reset = 1'b0;

    // Clean acquisition from reset
    valid_hdrs(63);
    check("lock_after_63", 32'(o_block_lock), 32'd0);
    valid_hdrs(1);
    check("lock_after_64", 32'(o_block_lock), 32'd1);
    check("no_slip_clean", 32'(slip_seen), 32'd0);

    // Bad header while hunting: one slip, 32 ignored headers, then reacquire
    do_reset();
    slip_en_cycles = 0;
    valid_hdrs(9);
    step(1'b1, 1'b1, HB0, 1'b0);
    check("slip_after_bad", 32'(o_grbx_slip), 32'd1);
    step(1'b1, 1'b0, HD, 1'b0);
    check("slip_cleared", 32'(o_grbx_slip), 32'd0);
    check("slip_one_cycle", 32'(slip_en_cycles), 32'd1);
    ign_hdrs(32);
    valid_hdrs(63);
    check("relock_63", 32'(o_block_lock), 32'd0);
    valid_hdrs(1);
    check("relock_64", 32'(o_block_lock), 32'd1);
    check("err_one", 32'(o_sh_err_cnt), 32'd1);

    // Locked: 15 bad per window holds lock, 16 bad in a window drops it
    window(15);
    check("win15_a", 32'(o_block_lock), 32'd1);
    window(15);
    check("win15_b", 32'(o_block_lock), 32'd1);
    check("err_31", 32'(o_sh_err_cnt), 32'd31);
    for (int i = 0; i < int'(SH_INVLD_MAX); i++) step(1'b1, 1'b1, HB1, 1'b0);
    check("drop_lock", 32'(o_block_lock), 32'd0);
    check("drop_slip", 32'(o_grbx_slip), 32'd1);

    // Slip pending across a clock-enable gap; disabled headers are inert
    repeat (3) step(1'b0, 1'b1, HB0, 1'b0);
    check("slip_held_gap", 32'(o_grbx_slip), 32'd1);
    check("err_47", 32'(o_sh_err_cnt), 32'd47);
    step(1'b1, 1'b0, HD, 1'b0);
    check("slip_gap_clr", 32'(o_grbx_slip), 32'd0);
    ign_hdrs(32);
    repeat (4) step(1'b0, 1'b1, HB1, 1'b0);
    check("en0_err", 32'(o_sh_err_cnt), 32'd47);
    check("en0_slip", 32'(o_grbx_slip), 32'd0);
    valid_hdrs(60);
    repeat (10) step(1'b0, 1'b1, HD, 1'b0);
    valid_hdrs(3);
    check("en0_no_count", 32'(o_block_lock), 32'd0);
    valid_hdrs(1);
    check("en0_lock", 32'(o_block_lock), 32'd1);

    // Saturate the error counter, then clear against a coincident error
    do_reset();
    for (int k = 0; k < 260; k++) begin
      step(1'b1, 1'b1, HB1, 1'b0);
      step(1'b1, 1'b0, HD, 1'b0);
      ign_hdrs(32);
    end
    check("err_sat", 32'(o_sh_err_cnt), 32'(ERR_MAX));
    step(1'b1, 1'b1, HB0, 1'b0);
    check("err_sat_hold", 32'(o_sh_err_cnt), 32'(ERR_MAX));
    step(1'b1, 1'b0, HD, 1'b0);
    ign_hdrs(32);
    step(1'b1, 1'b1, HB0, 1'b1);
    check("err_clr_prio", 32'(o_sh_err_cnt), 32'd0);
    step(1'b1, 1'b0, HD, 1'b0);
    ign_hdrs(32);

    // Reset during the slip wait, then reacquire
    step(1'b1, 1'b1, HB1, 1'b0);
    step(1'b1, 1'b0, HD, 1'b0);
    ign_hdrs(5);
    check("pre_rst_err", 32'(o_sh_err_cnt), 32'd1);
    do_reset();
    valid_hdrs(64);
    check("post_rst_lock", 32'(o_block_lock), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
